sobel_stream_3x3: RTL
=====================

# sobel_stream_3x3

Parametrised streaming 3x3 Sobel edge detector, the successor to the fixed 640-pixel line convolution stage. It accepts one grayscale pixel per handshake from the camera/grayscale path and holds two line buffers internally. It emits one edge magnitude per complete 3x3 window, with ready/valid backpressure on both sides, and feeds the SDRAM write FIFO. Image width and height, pixel width, output width and scaling are generics, and four output modes are selectable per frame.

## Interface
- IMG_W, 640: pixels per line; minimum 3.
- IMG_H, 480: lines per frame; minimum 3.
- PIX_W, 8: input pixel width, unsigned.
- OUT_W, 8: output width, unsigned.
- SHIFT, 2: right shift applied to the magnitude before saturation.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept a pixel this cycle.
- s_data  in  PIX_W  grayscale pixel, raster order.
- s_sof  in  1  qualifies s_data as pixel (0,0) of a new frame.
- cfg_mode  in  2  0 = L1 magnitude, 1 = |Gx|, 2 = |Gy|, 3 = binary threshold.
- cfg_thresh  in  OUT_W  threshold for mode 3.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the output.
- m_data  out  OUT_W  edge value.
- m_last  out  1  last output of a line.
- m_eof  out  1  last output of a frame.

## Operation
- Accept: s_valid && s_ready. Pipeline enable en = !m_valid || m_ready; s_ready = en, combinational.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accept.
  - col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both return to 0.
  - An accept with s_sof forces that pixel to position (0,0), including mid-frame. Outputs already in flight still drain.
- Config: cfg_mode and cfg_thresh are latched on an accept with s_sof and stay constant for the whole frame.
- Line buffers: two RAMs of IMG_W x PIX_W, addressed by col.
  - On accept, read lb0[col] and lb1[col] (old contents), then write lb0[col] = s_data and lb1[col] = old lb0[col].
  - Column taps: top = lb1 old, middle = lb0 old, bottom = s_data.
- Window: 3x3 shift registers p[r][c]; c = 2 is the newest column, r = 2 is the current line.
- A window is valid when the accepted pixel has row >= 2 and col >= 2. The output is centred on (row-1, col-1).
- Frame output count is (IMG_H-2)*(IMG_W-2). Border pixels produce no output.
- Gradients, signed, PIX_W+3 bits:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
- Magnitude, unsigned, PIX_W+4 bits:
  - mode 0: |Gx|+|Gy|; mode 1: |Gx|; mode 2: |Gy|.
  - Then v = mag >> SHIFT; m_data = (v > 2^OUT_W - 1) ? all ones : v.
- Mode 3: compute v as in mode 0, then m_data = (v >= thresh) ? all ones : 0.
- m_last = 1 for the output whose source pixel has col = IMG_W-1.
- m_eof = 1 for the output whose source pixel is (IMG_H-1, IMG_W-1).

## Timing
- Pipeline stages, each advancing only when en = 1:
  - S1: accept, RAM read, window shift.
  - S2: Gx/Gy registered.
  - S3: mode/abs/sum/saturate registered into m_data.
- Latency: m_valid rises 3 cycles after the accept of the window-completing pixel, given en held high.
- Stall: while m_valid && !m_ready, all stages, counters and RAM writes freeze. m_data, m_last and m_eof stay stable.
- Throughput: one pixel per cycle; no bubble across line or frame boundaries.
- Reset values: m_valid = 0, m_data = 0, m_last = 0, m_eof = 0, all stage valids = 0, row = col = 0, latched mode = 0, latched thresh = 0. s_ready = 1 after reset.
- RAM contents are not reset. Rows 0-1 of every frame refill them before any use.
- Reset mid-frame: outputs clear on assertion. The next accepted pixel is (0,0) regardless of s_sof.

## Test plan
- Flat frame, IMG_W=8, IMG_H=6, all pixels 100, mode 0 -> exactly 24 outputs, all 0. m_last on outputs 6, 12, 18, 24; m_eof on output 24 only.
- Vertical edge, IMG_W=8, IMG_H=6, columns 0-3 = 0 and 4-7 = 255, mode 1, SHIFT=2 -> every output line is 0,0,255,255,0,0 (raw |Gx| = 1020 saturates to 255). Same frame in mode 2 -> all 0.
- Horizontal edge, rows 0-2 = 0 and rows 3-5 = 255, mode 3, thresh 200 -> output rows 2 and 3 all 255, rows 1 and 4 all 0. A mode change mid-frame has no effect until the next s_sof.
- Backpressure: random m_ready with 50% duty plus one 10-cycle low burst on the vertical-edge frame -> identical output sequence. s_ready falls in the same cycle m_valid && !m_ready holds; no pixel lost or duplicated.
- Restart: s_sof asserted at pixel (3,4), then a full flat frame -> in-flight outputs drain, then exactly 24 flat-frame outputs of 0.
- Reset: rst pulsed during row 3, then a full vertical-edge frame without s_sof -> m_valid low after reset; the frame yields 24 correct outputs.

Source files
------------

// File: rtl/sobel_stream_3x3_if.sv
// Pixel-in / edge-out stream bundle for sobel_stream_3x3, with per-frame config.
// The master side drives pixels and downstream ready; the slave side is the filter.
interface sobel_stream_3x3_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_sof;
  logic [1:0]       cfg_mode;
  logic [OUT_W-1:0] cfg_thresh;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             m_eof;

  modport master (
    output s_valid, s_data, s_sof, cfg_mode, cfg_thresh, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_eof
  );

  modport slave (
    input  s_valid, s_data, s_sof, cfg_mode, cfg_thresh, m_ready,
    output s_ready, m_valid, m_data, m_last, m_eof
  );
endinterface

// File: rtl/sobel_stream_3x3.sv
// Streaming 3x3 Sobel edge detector with two line buffers; 3-cycle latency accept-to-output.
// A stalled output (m_valid && !m_ready) freezes every stage and drops s_ready the same cycle.
module sobel_stream_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  sobel_stream_3x3_if.slave bus
);
  localparam int CB = $clog2(IMG_W);
  localparam int RB = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int MW = PIX_W + 4;
  localparam int VW = (MW > OUT_W) ? MW : OUT_W;

  logic             r_mv;
  logic [OUT_W-1:0] r_md;
  logic             r_ml;
  logic             r_me;

  logic w_en;
  logic w_acc;
  assign w_en        = !r_mv || bus.m_ready;
  assign w_acc       = bus.s_valid && w_en;
  assign bus.s_ready = w_en;
  assign bus.m_valid = r_mv;
  assign bus.m_data  = r_md;
  assign bus.m_last  = r_ml;
  assign bus.m_eof   = r_me;

  // s_sof overrides the counters so the flagged pixel is treated as (0,0).
  logic [CB-1:0]    r_col;
  logic [RB-1:0]    r_row;
  logic [CB-1:0]    w_col;
  logic [RB-1:0]    w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic [1:0]       r_mode;
  logic [OUT_W-1:0] r_thresh;
  logic [1:0]       w_mode;
  logic [OUT_W-1:0] w_thresh;

  assign w_col      = bus.s_sof ? '0 : r_col;
  assign w_row      = bus.s_sof ? '0 : r_row;
  assign w_col_last = (w_col == CB'(IMG_W - 1));
  assign w_row_last = (w_row == RB'(IMG_H - 1));
  assign w_mode     = bus.s_sof ? bus.cfg_mode : r_mode;
  assign w_thresh   = bus.s_sof ? bus.cfg_thresh : r_thresh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= '0;
      r_thresh <= '0;
    end else if (w_acc) begin
      r_col <= w_col_last ? '0 : w_col + CB'(1);
      if (w_col_last) r_row <= w_row_last ? '0 : w_row + RB'(1);
      else            r_row <= w_row;
      if (bus.s_sof) begin
        r_mode   <= bus.cfg_mode;
        r_thresh <= bus.cfg_thresh;
      end
    end
  end

  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;
  assign w_top = r_lb1[w_col];
  assign w_mid = r_lb0[w_col];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_col] <= bus.s_data;
      r_lb1[w_col] <= w_mid;
    end
  end

  // Window p[row][col]: col 2 newest, row 2 current line.
  logic [PIX_W-1:0] r_p [3][3];
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_p[r][0] <= r_p[r][1];
        r_p[r][1] <= r_p[r][2];
      end
      r_p[0][2] <= w_top;
      r_p[1][2] <= w_mid;
      r_p[2][2] <= bus.s_data;
    end
  end

  logic             r_v1, r_l1, r_e1;
  logic [1:0]       r_mode1;
  logic [OUT_W-1:0] r_th1;
  logic             r_v2, r_l2, r_e2;
  logic [1:0]       r_mode2;
  logic [OUT_W-1:0] r_th2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_l1    <= 1'b0;
      r_e1    <= 1'b0;
      r_mode1 <= '0;
      r_th1   <= '0;
      r_v2    <= 1'b0;
      r_l2    <= 1'b0;
      r_e2    <= 1'b0;
      r_mode2 <= '0;
      r_th2   <= '0;
    end else if (w_en) begin
      r_v1    <= w_acc && (w_row >= RB'(2)) && (w_col >= CB'(2));
      r_l1    <= w_col_last;
      r_e1    <= w_col_last && w_row_last;
      r_mode1 <= w_mode;
      r_th1   <= w_thresh;
      r_v2    <= r_v1;
      r_l2    <= r_l1;
      r_e2    <= r_e1;
      r_mode2 <= r_mode1;
      r_th2   <= r_th1;
    end
  end

  function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] x);
    return GW'(x);
  endfunction

  // Gradients are two's complement in GW bits; the sign bit is handled by hand below.
  logic [GW-1:0] w_gx;
  logic [GW-1:0] w_gy;
  logic [GW-1:0] r_gx;
  logic [GW-1:0] r_gy;
  assign w_gx = (ext(r_p[0][2]) + (ext(r_p[1][2]) << 1) + ext(r_p[2][2]))
              - (ext(r_p[0][0]) + (ext(r_p[1][0]) << 1) + ext(r_p[2][0]));
  assign w_gy = (ext(r_p[2][0]) + (ext(r_p[2][1]) << 1) + ext(r_p[2][2]))
              - (ext(r_p[0][0]) + (ext(r_p[0][1]) << 1) + ext(r_p[0][2]));

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_gx <= w_gx;
      r_gy <= w_gy;
    end
  end

  logic [GW-1:0]    w_axn;
  logic [GW-1:0]    w_ayn;
  logic [MW-1:0]    w_mag;
  logic [VW-1:0]    w_v;
  logic [OUT_W-1:0] w_sat;
  logic [OUT_W-1:0] w_bin;
  logic [OUT_W-1:0] w_out;

  always_comb begin
    w_axn = r_gx[GW-1] ? (~r_gx + GW'(1)) : r_gx;
    w_ayn = r_gy[GW-1] ? (~r_gy + GW'(1)) : r_gy;
    w_mag = MW'(w_axn) + MW'(w_ayn);
    case (r_mode2)
      2'd1:    w_mag = MW'(w_axn);
      2'd2:    w_mag = MW'(w_ayn);
      default: w_mag = MW'(w_axn) + MW'(w_ayn);
    endcase
    w_v   = VW'(w_mag) >> SHIFT;
    w_sat = (w_v > VW'({OUT_W{1'b1}})) ? '1 : w_v[OUT_W-1:0];
    w_bin = (w_v >= VW'(r_th2)) ? '1 : '0;
    w_out = (r_mode2 == 2'd3) ? w_bin : w_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mv <= 1'b0;
      r_md <= '0;
      r_ml <= 1'b0;
      r_me <= 1'b0;
    end else if (w_en) begin
      r_mv <= r_v2;
      if (r_v2) begin
        r_md <= w_out;
        r_ml <= r_l2;
        r_me <= r_e2;
      end
    end
  end
endmodule
